// File: rtl/apb_cmd_master_pkg.sv
// Shared types for the APB command master: FSM encoding and the captured-command record.
// The capture record is sized for the widest supported bus; narrower top-level widths use the low bits.
package apb_cmd_master_pkg;

  localparam int CMD_DATA_W = 32;
  localparam int CMD_ADDR_W = 32;
  localparam int CMD_STRB_W = CMD_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  typedef struct packed {
    logic                  write;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
    logic [CMD_STRB_W-1:0] strb;
    logic [2:0]            prot;
  } cmd_t;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS wait-state counter: hit is high once G_TIMEOUT un-ready cycles have elapsed since clear.
// Combinational hit from a registered count; G_TIMEOUT=0 ties hit low and removes the counter.
module apb_timeout_cnt #(
  parameter int G_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  if (G_TIMEOUT == 0) begin : g_off
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst, clear, enable};
    assign hit           = 1'b0;
  end else begin : g_cnt
    localparam int CW = $clog2(G_TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
        cnt_d = '0;
      end else if (enable && (cnt_q != CW'(G_TIMEOUT))) begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign hit = (cnt_q == CW'(G_TIMEOUT));
  end

endmodule

// File: rtl/apb_cmd_master.sv
// APB4 requester: one valid/ready command becomes one SETUP/ACCESS transfer; 3 cycles handshake-to-response plus wait states.
// Single outstanding transfer: cmd_ready stays low until the registered response is taken with rsp_ready.
module apb_cmd_master
  import apb_cmd_master_pkg::*;
#(
  parameter int G_REGWIDTH   = 32,
  parameter int G_ADDR_WIDTH = 32,
  parameter int G_TIMEOUT    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [G_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [G_REGWIDTH-1:0]     cmd_wdata,
  input  logic [G_REGWIDTH/8-1:0]   cmd_strb,
  input  logic [2:0]                cmd_prot,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [G_REGWIDTH-1:0]     rsp_rdata,
  output logic                      rsp_slverr,
  output logic                      rsp_timeout,
  output logic                      m_apb_psel,
  output logic                      m_apb_penable,
  output logic                      m_apb_pwrite,
  output logic [2:0]                m_apb_pprot,
  output logic [G_ADDR_WIDTH-1:0]   m_apb_paddr,
  output logic [G_REGWIDTH-1:0]     m_apb_pwdata,
  output logic [G_REGWIDTH/8-1:0]   m_apb_pstrb,
  input  logic                      m_apb_pready,
  input  logic                      m_apb_pslverr,
  input  logic [G_REGWIDTH-1:0]     m_apb_prdata
);

  localparam int STRB_W = G_REGWIDTH / 8;

  state_t                state_q, state_d;
  cmd_t                  cmd_q, cmd_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [G_REGWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_slverr_q, rsp_slverr_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic                  cnt_clr, cnt_en, cnt_hit;

  apb_timeout_cnt #(
    .G_TIMEOUT(G_TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clr),
    .enable(cnt_en),
    .hit   (cnt_hit)
  );

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_slverr_d  = rsp_slverr_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_clr       = 1'b0;
    cnt_en        = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_d                       = '0;
          cmd_d.write                 = cmd_write;
          cmd_d.addr[G_ADDR_WIDTH-1:0] = cmd_addr;
          cmd_d.wdata[G_REGWIDTH-1:0] = cmd_wdata;
          // Reads never present byte strobes on the bus.
          cmd_d.strb[STRB_W-1:0]      = cmd_write ? cmd_strb : '0;
          cmd_d.prot                  = cmd_prot;
          cnt_clr                     = 1'b1;
          state_d                     = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        // A completing pready outranks a timeout reached in the same cycle.
        if (m_apb_pready) begin
          rsp_rdata_d   = cmd_q.write ? '0 : m_apb_prdata;
          rsp_slverr_d  = m_apb_pslverr;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end else if (cnt_hit) begin
          rsp_rdata_d   = '0;
          rsp_slverr_d  = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end else begin
          cnt_en = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d   = 1'b0;
          rsp_timeout_d = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered outputs are computed from the next state so they line up with it.
    cmd_ready_d = (state_d == IDLE);
    psel_d      = (state_d == SETUP) || (state_d == ACCESS);
    penable_d   = (state_d == ACCESS);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cmd_q         <= '0;
      cmd_ready_q   <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      cmd_ready_q   <= cmd_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_slverr_q  <= rsp_slverr_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_slverr    = rsp_slverr_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign m_apb_psel    = psel_q;
  assign m_apb_penable = penable_q;
  assign m_apb_pwrite  = cmd_q.write;
  assign m_apb_pprot   = cmd_q.prot;
  assign m_apb_paddr   = cmd_q.addr[G_ADDR_WIDTH-1:0];
  assign m_apb_pwdata  = cmd_q.wdata[G_REGWIDTH-1:0];
  assign m_apb_pstrb   = cmd_q.strb[STRB_W-1:0];

endmodule

// File: tb/tb_apb_cmd_master.sv
// Scoreboard bench for apb_cmd_master: a driver queues expected responses, an APB slave model
// checks bus phases, and a response monitor compares every delivered response.
module tb_apb_cmd_master;

  localparam int G_TO = 16;

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          waits;
    logic        serr;
    logic [31:0] rd;
  } xfer_t;

  typedef struct {
    logic [31:0] rdata;
    logic        serr;
    logic        tmo;
    int          hs;
    int          lat;
  } exp_t;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid, rsp_ready, rsp_slverr, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        m_apb_psel, m_apb_penable, m_apb_pwrite;
  logic [2:0]  m_apb_pprot;
  logic [31:0] m_apb_paddr, m_apb_pwdata, m_apb_prdata;
  logic [3:0]  m_apb_pstrb;
  logic        m_apb_pready, m_apb_pslverr;

  int    n_chk = 0;
  int    n_pass = 0;
  int    cyc = 0;
  bit    rdy_force = 1'b1;
  xfer_t slv_q[$];
  exp_t  exp_q[$];

  apb_cmd_master #(
    .G_REGWIDTH  (32),
    .G_ADDR_WIDTH(32),
    .G_TIMEOUT   (G_TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_strb     (cmd_strb),
    .cmd_prot     (cmd_prot),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_slverr   (rsp_slverr),
    .rsp_timeout  (rsp_timeout),
    .m_apb_psel   (m_apb_psel),
    .m_apb_penable(m_apb_penable),
    .m_apb_pwrite (m_apb_pwrite),
    .m_apb_pprot  (m_apb_pprot),
    .m_apb_paddr  (m_apb_paddr),
    .m_apb_pwdata (m_apb_pwdata),
    .m_apb_pstrb  (m_apb_pstrb),
    .m_apb_pready (m_apb_pready),
    .m_apb_pslverr(m_apb_pslverr),
    .m_apb_prdata (m_apb_prdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: run still active at time limit, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Expected result straight from the transfer rules: pready at wait index <= G_TO completes normally.
  function automatic exp_t model(input xfer_t x, input int hs);
    exp_t e;
    e.hs = hs;
    if (x.waits > G_TO) begin
      e.rdata = 32'h0;
      e.serr  = 1'b1;
      e.tmo   = 1'b1;
      e.lat   = 3 + G_TO;
    end else begin
      e.rdata = x.w ? 32'h0 : x.rd;
      e.serr  = x.serr;
      e.tmo   = 1'b0;
      e.lat   = 3 + x.waits;
    end
    return e;
  endfunction

  function automatic logic [39:0] ctl_exp(input xfer_t s);
    return {s.w, s.wdata, (s.w ? s.strb : 4'h0), s.prot};
  endfunction

  function automatic logic [39:0] ctl_act();
    return {m_apb_pwrite, m_apb_pwdata, m_apb_pstrb, m_apb_pprot};
  endfunction

  // Called at posedge+1; returns at posedge+1 of the handshake edge.
  task automatic send(input xfer_t x, output int hs);
    int n;
    bit ok;
    slv_q.push_back(x);
    cmd_write = x.w;
    cmd_addr  = x.addr;
    cmd_wdata = x.wdata;
    cmd_strb  = x.strb;
    cmd_prot  = x.prot;
    cmd_valid = 1'b1;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 300) begin
      @(negedge clk);
      ok = (cmd_ready === 1'b1);
      n++;
    end
    @(posedge clk);
    #1;
    hs        = cyc;
    cmd_valid = 1'b0;
    chk("cmd_accept", 64'(ok), 64'd1);
    if (ok) exp_q.push_back(model(x, hs));
    else void'(slv_q.pop_back());
  endtask

  // APB slave model: checks SETUP/ACCESS contents and supplies pready after the chosen wait count.
  initial begin
    xfer_t s;
    int    acc;
    bit    active;
    active = 1'b0;
    acc    = 0;
    m_apb_pready  = 1'b0;
    m_apb_pslverr = 1'b0;
    m_apb_prdata  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      m_apb_pready  = 1'b0;
      m_apb_pslverr = 1'($urandom_range(1));
      m_apb_prdata  = $urandom;
      if (!rst) begin
        active = 1'b0;
      end else if (m_apb_psel && !m_apb_penable) begin
        if (slv_q.size() == 0) begin
          n_chk++;
          $display("FAIL apb_setup: psel=1 with no command issued, required psel=0");
          active = 1'b0;
        end else begin
          s      = slv_q.pop_front();
          active = 1'b1;
          acc    = 0;
          chk("apb_setup_addr", 64'(m_apb_paddr), 64'(s.addr));
          chk("apb_setup_ctl", 64'(ctl_act()), 64'(ctl_exp(s)));
        end
      end else if (m_apb_psel && m_apb_penable && active) begin
        chk("apb_access_hold", 64'({m_apb_paddr, ctl_act()}), 64'({s.addr, ctl_exp(s)}));
        if (acc == s.waits) begin
          m_apb_pready  = 1'b1;
          m_apb_pslverr = s.serr;
          m_apb_prdata  = s.rd;
        end
        acc++;
      end else if (!m_apb_psel && active) begin
        active = 1'b0;
        chk("apb_access_cycles", 64'(acc), 64'(((s.waits > G_TO) ? G_TO : s.waits) + 1));
      end
    end
  end

  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!rdy_force) rsp_ready = ($urandom_range(3) != 0);
    end
  end

  // Response monitor.
  exp_t        cur;
  bit          seen = 1'b0;
  logic [33:0] held;

  always @(negedge clk) begin
    if (rst && rsp_valid) begin
      if (!seen) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL rsp_unexpected: rsp_valid=1, required 0 (no transfer outstanding)");
        end else begin
          cur  = exp_q[0];
          seen = 1'b1;
          held = {rsp_rdata, rsp_slverr, rsp_timeout};
          chk("rsp_latency", 64'(cyc - cur.hs + 1), 64'(cur.lat));
          chk("rsp_rdata", 64'(rsp_rdata), 64'(cur.rdata));
          chk("rsp_slverr", 64'(rsp_slverr), 64'(cur.serr));
          chk("rsp_timeout", 64'(rsp_timeout), 64'(cur.tmo));
          chk("rsp_apb_idle", 64'({m_apb_psel, m_apb_penable}), 64'd0);
        end
      end else begin
        chk("rsp_stable", 64'({rsp_rdata, rsp_slverr, rsp_timeout}), 64'(held));
      end
      if (rsp_ready && seen) begin
        seen = 1'b0;
        void'(exp_q.pop_front());
      end
    end
  end

  xfer_t x, x2;
  int    hs, hs2, hs_prev, r_edge, stale, n;

  initial begin
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0;
    cmd_wdata = 32'h0;
    cmd_strb  = 4'h0;
    cmd_prot  = 3'h0;

    repeat (3) @(negedge clk);
    chk("reset_outputs",
        64'({cmd_ready, rsp_valid, rsp_slverr, rsp_timeout, m_apb_psel, m_apb_penable,
             m_apb_pwrite, m_apb_pprot, m_apb_pstrb}), 64'd0);
    chk("reset_buses", 64'({rsp_rdata, m_apb_paddr}), 64'd0);
    chk("reset_pwdata", 64'(m_apb_pwdata), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);

    // Directed: write, read with waits, slave error, timeout, timeout boundaries.
    x = '{w: 1'b1, addr: 32'h10, wdata: 32'hDEADBEEF, strb: 4'hF, prot: 3'h2, waits: 0, serr: 1'b0, rd: 32'hA5A5A5A5};
    send(x, hs);
    x = '{w: 1'b0, addr: 32'h20, wdata: 32'h0BAD0BAD, strb: 4'hF, prot: 3'h1, waits: 3, serr: 1'b0, rd: 32'h12345678};
    send(x, hs);
    x = '{w: 1'b0, addr: 32'h24, wdata: 32'h0, strb: 4'h3, prot: 3'h0, waits: 1, serr: 1'b1, rd: 32'hCAFEF00D};
    send(x, hs);
    x = '{w: 1'b0, addr: 32'h28, wdata: 32'h0, strb: 4'h0, prot: 3'h7, waits: 1000, serr: 1'b0, rd: 32'h11111111};
    send(x, hs);
    x = '{w: 1'b0, addr: 32'h2C, wdata: 32'h0, strb: 4'h0, prot: 3'h4, waits: G_TO, serr: 1'b0, rd: 32'h22222222};
    send(x, hs);
    x = '{w: 1'b1, addr: 32'h30, wdata: 32'h33333333, strb: 4'h5, prot: 3'h3, waits: G_TO + 1, serr: 1'b0, rd: 32'h0};
    send(x, hs);

    // Back-to-back throughput with immediate pready and rsp_ready high.
    hs_prev = 0;
    for (int i = 0; i < 5; i++) begin
      x = '{w: 1'b1, addr: 32'h100 + 32'(i * 4), wdata: $urandom, strb: 4'hF, prot: 3'h0, waits: 0, serr: 1'b0, rd: 32'h0};
      send(x, hs);
      if (i > 0) chk("throughput", 64'(hs - hs_prev), 64'd4);
      hs_prev = hs;
    end

    // Response backpressure with a second command waiting.
    repeat (4) @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    x  = '{w: 1'b0, addr: 32'h40, wdata: 32'h0, strb: 4'h0, prot: 3'h0, waits: 0, serr: 1'b0, rd: 32'h76543210};
    x2 = '{w: 1'b1, addr: 32'h44, wdata: 32'h55AA55AA, strb: 4'hC, prot: 3'h6, waits: 2, serr: 1'b1, rd: 32'h0};
    send(x, hs);
    fork
      send(x2, hs2);
      begin
        repeat (10) begin
          @(negedge clk);
          chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        r_edge    = cyc;
      end
    join
    chk("bp_setup_delay", 64'(hs2 - r_edge), 64'd2);

    // Reset pulse during ACCESS discards the pending transfer.
    repeat (25) @(posedge clk);
    #1;
    x = '{w: 1'b0, addr: 32'h50, wdata: 32'h0, strb: 4'h0, prot: 3'h0, waits: 1000, serr: 1'b0, rd: 32'h0};
    send(x, hs);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("rst_async", 64'({m_apb_psel, m_apb_penable, rsp_valid, cmd_ready}), 64'd0);
    exp_q.delete();
    slv_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    stale = 0;
    repeat (25) begin
      @(negedge clk);
      if (rsp_valid) stale++;
    end
    chk("rst_no_stale_rsp", 64'(stale), 64'd0);
    @(posedge clk);
    #1;

    // Randomized traffic with random response backpressure.
    rdy_force = 1'b0;
    for (int i = 0; i < 150; i++) begin
      x.w     = 1'($urandom_range(1));
      x.addr  = $urandom;
      x.wdata = $urandom;
      x.strb  = 4'($urandom_range(15));
      x.prot  = 3'($urandom_range(7));
      x.serr  = 1'($urandom_range(1));
      x.rd    = $urandom;
      case ($urandom_range(9))
        6:       x.waits = G_TO - 1;
        7:       x.waits = G_TO;
        8:       x.waits = G_TO + 1;
        9:       x.waits = 300;
        default: x.waits = int'($urandom_range(3));
      endcase
      send(x, hs);
      repeat ($urandom_range(2)) begin
        @(posedge clk);
        #1;
      end
    end

    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_responses", 64'(exp_q.size()), 64'd0);
    chk("drain_apb", 64'(slv_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
